down_sampler: RTL and testbench
===============================

Name: down_sampler

Overview:
- Streaming decimator: one input sample per i_clk cycle; produces three decimated outputs at 1/2, 1/4 and 1/8 of the input rate.
- Each output is the boxcar average (floor mean) of the N most recent non-overlapping input samples (N = 2, 4, 8). The output is held between updates.
- Sits between a sample source and downstream rate-reduced processing or monitoring. There is no handshake; every clock edge consumes one sample.

Parameters:
- DATA_WIDTH, 16, width of the input sample and of each output (unsigned).

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_data  input  DATA_WIDTH  unsigned input sample, consumed on every rising edge.
- o_ds2  output  DATA_WIDTH  floor mean of each group of 2 samples, registered.
- o_ds4  output  DATA_WIDTH  floor mean of each group of 4 samples, registered.
- o_ds8  output  DATA_WIDTH  floor mean of each group of 8 samples, registered.

Behaviour:
- Clocking and reset: one clock. i_rst is asynchronous and active-low.
- While i_rst=0, these are all 0: the phase counter, every accumulator, o_ds2, o_ds4 and o_ds8.
- Phase counter: cnt is 3 bits, reset to 0, and increments modulo 8 on every rising edge with i_rst=1.
- Sample k after reset release is the sample taken on the edge where cnt=k mod 8. Groups are phase-aligned to reset release.
- Accumulation: each decimation stage keeps an accumulator of width DATA_WIDTH+log2(N). It adds i_data on every edge.
- Group boundaries (last sample of the group):
  - ds2: cnt[0]=1
  - ds4: cnt[1:0]=3
  - ds8: cnt=7
- On a boundary edge:
  - output <= (acc + i_data) >> log2(N), i.e. truncating division.
  - acc <= 0, so the next group starts fresh.
- Latency: an output becomes visible immediately after the edge that samples the last sample of its group.
  - o_ds2 changes once every 2 cycles, o_ds4 once every 4, o_ds8 once every 8.
- Outputs hold their value between boundary edges.
- Arithmetic: unsigned only. The accumulator width guarantees no overflow. Full-scale input gives a full-scale output.
- Each stage sums raw input samples independently. o_ds4 is NOT derived from o_ds2, which avoids compounded truncation.
- Reset mid-group: partial sums are discarded and the counter restarts at 0. Outputs read 0 until the first full group completes after release.
- Initial outputs after reset release:
  - o_ds2 = 0 until edge #2
  - o_ds4 = 0 until edge #4
  - o_ds8 = 0 until edge #8
- No valid strobes. Downstream logic must derive update timing from reset release if needed.

Decomposition:
- Shared package down_sampler_pkg holds:
  - DATA_WIDTH default (16)
  - the decimation factors as localparams: 2, 4, 8, with log2 values 1, 2, 3
- One sub-module, decim_avg, parameterised by DATA_WIDTH and LOG2_N.
  - Inputs: clock, reset, data, boundary strobe.
  - Contains the accumulator and output register.
- Top level: the shared 3-bit phase counter, three decim_avg instances, and boundary decode from cnt.

Test Plan:
- Reset: hold i_rst=0 for 5 cycles with i_data=1234 -> all outputs 0 throughout. Assert i_rst mid-cycle -> outputs clear immediately, without waiting for a clock edge.
- Ramp: after release feed 0,1,2,…,7 ->
  - o_ds2 = 0, 2, 4, 6 (updates after edges 2, 4, 6, 8)
  - o_ds4 = 1 after edge 4, 5 after edge 8
  - o_ds8 = 3 after edge 8
- Constant: feed 100 for 16 cycles -> o_ds2, o_ds4 and o_ds8 all settle to 100 and remain 100. Check held values between updates.
- Full scale: feed 65535 for 8 cycles -> all outputs 65535, with no wrap.
- Truncation: feed 1,2 -> o_ds2=1. Feed 1,1,1,2 -> o_ds4=1. Feed seven 0s then 7 -> o_ds8=0.
- Reset mid-group: feed 8,8,8, then pulse i_rst low, release, then feed 2,4,… -> partial sums discarded. First o_ds2 after release = 3; o_ds4 and o_ds8 stay 0 until their first full post-reset groups.

Source files
------------

// File: rtl/down_sampler_pkg.sv
// Purpose: shared constants for the down_sampler decimator (sample width, decimation factors).
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package down_sampler_pkg;

    // Default sample width. Samples are unsigned.
    localparam int DS_DATA_WIDTH = 16;

    // Decimation factors and their log2 values. Each stage averages
    // 2**LOG2 consecutive samples, so the division is a right shift.
    localparam int DS2_N    = 2;
    localparam int DS4_N    = 4;
    localparam int DS8_N    = 8;
    localparam int DS2_LOG2 = 1;
    localparam int DS4_LOG2 = 2;
    localparam int DS8_LOG2 = 3;

    // Width of the shared phase counter. It must cover the largest factor.
    localparam int DS_CNT_WIDTH = DS8_LOG2;

endpackage

// File: rtl/decim_avg.sv
// Purpose: one boxcar-average stage that sums raw samples and emits floor(sum / 2**LOG2_N) when a group closes.
// Latency: the output register updates on the edge that samples the last sample of a group.
// Backpressure: none; one sample is consumed on every edge.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-low reset; clears the accumulator and the output
//   i_data     unsigned input sample
//   i_boundary high on the edge that carries the last sample of a group
//   o_avg      registered floor mean of the most recent complete group
module decim_avg
    import down_sampler_pkg::*;
#(
    parameter int DATA_WIDTH = DS_DATA_WIDTH,
    parameter int LOG2_N     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_boundary,
    output logic [DATA_WIDTH-1:0] o_avg
);

    localparam int ACC_WIDTH = DATA_WIDTH + LOG2_N;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;

    // acc holds at most N-1 samples when the current sample is added, so
    // N full-scale samples still fit in ACC_WIDTH bits without wrapping.
    assign sum = acc + ACC_WIDTH'(i_data);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc   <= '0;
            o_avg <= '0;
        end else if (i_boundary) begin
            // Dropping the low LOG2_N bits gives the truncating division.
            o_avg <= sum[ACC_WIDTH-1:LOG2_N];
            acc   <= '0;
        end else begin
            acc   <= sum;
        end
    end

endmodule

// File: rtl/down_sampler.sv
// Purpose: streaming decimator producing floor-mean averages at 1/2, 1/4 and 1/8 of the input rate.
// Latency: each output updates right after the edge that samples the last sample of its group, and holds until the next group closes.
// Backpressure: none; i_data is consumed on every rising edge.
//
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-low reset
//   i_data  unsigned input sample
//   o_ds2   floor mean of each group of 2 samples
//   o_ds4   floor mean of each group of 4 samples
//   o_ds8   floor mean of each group of 8 samples
module down_sampler
    import down_sampler_pkg::*;
#(
    parameter int DATA_WIDTH = DS_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_ds2,
    output logic [DATA_WIDTH-1:0] o_ds4,
    output logic [DATA_WIDTH-1:0] o_ds8
);

    logic [DS_CNT_WIDTH-1:0] cnt;
    logic                    bnd2;
    logic                    bnd4;
    logic                    bnd8;

    // The phase counter restarts at 0 on reset release, so every group is
    // aligned to the first sample after release and a partial group
    // interrupted by reset is discarded.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A group closes when the low log2(N) counter bits are all ones.
    assign bnd2 = cnt[0];
    assign bnd4 = &cnt[1:0];
    assign bnd8 = &cnt;

    // Each stage sums raw samples on its own so that truncation errors do
    // not compound from one stage to the next.
    decim_avg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (DS2_LOG2)
    ) u_ds2 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_boundary (bnd2),
        .o_avg      (o_ds2)
    );

    decim_avg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (DS4_LOG2)
    ) u_ds4 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_boundary (bnd4),
        .o_avg      (o_ds4)
    );

    decim_avg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (DS8_LOG2)
    ) u_ds8 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_boundary (bnd8),
        .o_avg      (o_ds8)
    );

endmodule

// File: tb/tb_down_sampler.sv
// Purpose: directed self-checking bench for down_sampler with hand-computed expected outputs.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a; one sample is driven per cycle.
module tb_down_sampler;

    localparam int DW = 16;

    logic          i_clk;
    logic          i_rst;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_ds2;
    logic [DW-1:0] o_ds4;
    logic [DW-1:0] o_ds8;

    int checks;
    int failures;

    down_sampler #(.DATA_WIDTH(DW)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .o_ds2  (o_ds2),
        .o_ds4  (o_ds4),
        .o_ds8  (o_ds8)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample between edges, then sample outputs just after the edge.
    task automatic step(input logic [DW-1:0] d);
        i_data = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [DW-1:0] d,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e4,
                            input logic [DW-1:0] e8);
        step(d);
        check_val({tag, " ds2"}, o_ds2, e2);
        check_val({tag, " ds4"}, o_ds4, e4);
        check_val({tag, " ds8"}, o_ds8, e8);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        i_rst    = 1'b0;
        i_data   = '0;

        // Reset held with nonzero input: outputs stay 0.
        for (int i = 0; i < 5; i++) step_chk("reset", 16'd1234, 16'd0, 16'd0, 16'd0);
        i_rst = 1'b1;

        // Ramp 0..7.
        step_chk("ramp e1", 16'd0, 16'd0, 16'd0, 16'd0);
        step_chk("ramp e2", 16'd1, 16'd0, 16'd0, 16'd0);
        step_chk("ramp e3", 16'd2, 16'd0, 16'd0, 16'd0);
        step_chk("ramp e4", 16'd3, 16'd2, 16'd1, 16'd0);
        step_chk("ramp e5", 16'd4, 16'd2, 16'd1, 16'd0);
        step_chk("ramp e6", 16'd5, 16'd4, 16'd1, 16'd0);
        step_chk("ramp e7", 16'd6, 16'd4, 16'd1, 16'd0);
        step_chk("ramp e8", 16'd7, 16'd6, 16'd5, 16'd3);

        // Constant 100 for 16 cycles; earlier values held until each group closes.
        for (int i = 0; i < 16; i++) begin
            step_chk("const", 16'd100,
                     (i >= 1) ? 16'd100 : 16'd6,
                     (i >= 3) ? 16'd100 : 16'd5,
                     (i >= 7) ? 16'd100 : 16'd3);
        end

        // Full scale: no wrap in any accumulator.
        for (int i = 0; i < 8; i++) begin
            step_chk("full", 16'd65535,
                     (i >= 1) ? 16'd65535 : 16'd100,
                     (i >= 3) ? 16'd65535 : 16'd100,
                     (i >= 7) ? 16'd65535 : 16'd100);
        end

        // Truncation: 1,2 -> 1; 1,1,1,2 -> 1; 8-sum 14 -> 1.
        step_chk("trunc a1", 16'd1, 16'd65535, 16'd65535, 16'd65535);
        step_chk("trunc a2", 16'd2, 16'd1,     16'd65535, 16'd65535);
        step_chk("trunc a3", 16'd3, 16'd1,     16'd65535, 16'd65535);
        step_chk("trunc a4", 16'd3, 16'd3,     16'd2,     16'd65535);
        step_chk("trunc a5", 16'd1, 16'd3,     16'd2,     16'd65535);
        step_chk("trunc a6", 16'd1, 16'd1,     16'd2,     16'd65535);
        step_chk("trunc a7", 16'd1, 16'd1,     16'd2,     16'd65535);
        step_chk("trunc a8", 16'd2, 16'd1,     16'd1,     16'd1);

        // Seven zeros then 7: ds8 = 0, ds4 = 1, ds2 = 3.
        step_chk("trunc b1", 16'd0, 16'd1, 16'd1, 16'd1);
        step_chk("trunc b2", 16'd0, 16'd0, 16'd1, 16'd1);
        step_chk("trunc b3", 16'd0, 16'd0, 16'd1, 16'd1);
        step_chk("trunc b4", 16'd0, 16'd0, 16'd0, 16'd1);
        step_chk("trunc b5", 16'd0, 16'd0, 16'd0, 16'd1);
        step_chk("trunc b6", 16'd0, 16'd0, 16'd0, 16'd1);
        step_chk("trunc b7", 16'd0, 16'd0, 16'd0, 16'd1);
        step_chk("trunc b8", 16'd7, 16'd3, 16'd1, 16'd0);

        // Partial group of 8s, then an asynchronous reset between edges.
        step_chk("mid e1", 16'd8, 16'd3, 16'd1, 16'd0);
        step_chk("mid e2", 16'd8, 16'd8, 16'd1, 16'd0);
        step_chk("mid e3", 16'd8, 16'd8, 16'd1, 16'd0);
        #2;
        i_rst = 1'b0;
        #1;
        check_val("async rst ds2", o_ds2, 16'd0);
        check_val("async rst ds4", o_ds4, 16'd0);
        check_val("async rst ds8", o_ds8, 16'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;

        // Ramp by 2 after release: groups restart from the first sample.
        step_chk("post e1", 16'd2,  16'd0,  16'd0,  16'd0);
        step_chk("post e2", 16'd4,  16'd3,  16'd0,  16'd0);
        step_chk("post e3", 16'd6,  16'd3,  16'd0,  16'd0);
        step_chk("post e4", 16'd8,  16'd7,  16'd5,  16'd0);
        step_chk("post e5", 16'd10, 16'd7,  16'd5,  16'd0);
        step_chk("post e6", 16'd12, 16'd11, 16'd5,  16'd0);
        step_chk("post e7", 16'd14, 16'd11, 16'd5,  16'd0);
        step_chk("post e8", 16'd16, 16'd15, 16'd13, 16'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
